// File: rtl/dvs_event_accumulator.sv
// DVS event integrator: per-pixel saturating counts over a timestamp window, drained row-major on close (optional DVS_ACCUM_STATS_EN adds frame_events_o).
// Latency: event visible 1 cycle after accept, first pixel 1 cycle after close; ready_o drops on close, drain stalls on ready_i.
module dvs_event_accumulator #(
   parameter int WIDTH_P   = 8,
   parameter int HEIGHT_P  = 8,
   parameter int COUNT_W_P = 8,
   parameter int WINDOW_P  = 1000
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          valid_i,
   input  logic [$clog2(WIDTH_P)-1:0]    x_i,
   input  logic [$clog2(HEIGHT_P)-1:0]   y_i,
   input  logic                          polarity_i,
   input  logic [15:0]                   timestamp_i,
   output logic                          ready_o,
   input  logic                          flush_i,
   output logic                          valid_o,
   output logic [$clog2(WIDTH_P)-1:0]    x_o,
   output logic [$clog2(HEIGHT_P)-1:0]   y_o,
   output logic signed [COUNT_W_P-1:0]   count_o,
   output logic                          last_o,
   input  logic                          ready_i
`ifdef DVS_ACCUM_STATS_EN
   ,
   output logic [15:0]                   frame_events_o
`endif
);

   localparam int X_W = $clog2(WIDTH_P);
   localparam int Y_W = $clog2(HEIGHT_P);
   localparam logic [X_W:0] W_LIM  = (X_W+1)'(WIDTH_P);
   localparam logic [Y_W:0] H_LIM  = (Y_W+1)'(HEIGHT_P);
   localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH_P - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT_P - 1);
   localparam logic [15:0] WIN_L = 16'(WINDOW_P);
   localparam logic signed [COUNT_W_P-1:0] CNT_MAX = {1'b0, {(COUNT_W_P-1){1'b1}}};
   localparam logic signed [COUNT_W_P-1:0] CNT_MIN = {1'b1, {(COUNT_W_P-1){1'b0}}};

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t state, state_nxt;
   logic signed [COUNT_W_P-1:0] cnt [HEIGHT_P][WIDTH_P];
   logic [15:0]    t_start;
   logic [15:0]    delta;
   logic           window_open;
   logic [X_W-1:0] dx;
   logic [Y_W-1:0] dy;
   logic           close_req;
   logic           accept;
   logic           in_range;
   logic           hs;
   logic           at_last;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= ACCUM;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      last_o    = 1'b0;
      x_o       = '0;
      y_o       = '0;
      count_o   = '0;
      // wrap-safe window age: modulo-2^16 difference
      delta     = timestamp_i - t_start;
      in_range  = ({1'b0, x_i} < W_LIM) && ({1'b0, y_i} < H_LIM);
      at_last   = (dx == X_LAST) && (dy == Y_LAST);
      close_req = (state == ACCUM) && window_open &&
                  ((valid_i && (delta >= WIN_L)) || flush_i);
      case (state)
         ACCUM: begin
            ready_o = ~close_req;
            if (close_req) state_nxt = DRAIN;
         end
         DRAIN: begin
            valid_o = 1'b1;
            x_o     = dx;
            y_o     = dy;
            count_o = cnt[dy][dx];
            last_o  = at_last;
            if (ready_i && at_last) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
      accept = valid_i & ready_o;
      hs     = valid_o & ready_i;
   end

   // Accumulate and drain never overlap, so one write port per cycle suffices.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int r = 0; r < HEIGHT_P; r++)
            for (int c = 0; c < WIDTH_P; c++)
               cnt[r][c] <= '0;
      end else if (accept && in_range) begin
         if (polarity_i) begin
            if (cnt[y_i][x_i] != CNT_MAX) cnt[y_i][x_i] <= cnt[y_i][x_i] + COUNT_W_P'(1);
         end else begin
            if (cnt[y_i][x_i] != CNT_MIN) cnt[y_i][x_i] <= cnt[y_i][x_i] - COUNT_W_P'(1);
         end
      end else if (hs) begin
         cnt[dy][dx] <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         window_open <= 1'b0;
         t_start     <= '0;
         dx          <= '0;
         dy          <= '0;
      end else begin
         if (accept && !window_open) begin
            window_open <= 1'b1;
            t_start     <= timestamp_i;
         end
         if (hs) begin
            if (at_last) begin
               dx          <= '0;
               dy          <= '0;
               window_open <= 1'b0;
            end else if (dx == X_LAST) begin
               dx <= '0;
               dy <= dy + Y_W'(1);
            end else begin
               dx <= dx + X_W'(1);
            end
         end
      end
   end

`ifdef DVS_ACCUM_STATS_EN
   logic [15:0] frame_events;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                                        frame_events <= '0;
      else if (hs && at_last)                             frame_events <= '0;
      else if (accept && in_range && frame_events != 16'hFFFF) frame_events <= frame_events + 16'd1;
   end

   assign frame_events_o = frame_events;
`endif

endmodule

// File: tb/tb_dvs_event_accumulator.sv
// Bench for dvs_event_accumulator: directed events, expected frames queued and checked by a pixel monitor.
module tb_dvs_event_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [2:0]  x_i = '0;
   logic [2:0]  y_i = '0;
   logic        pol = 1'b0;
   logic [15:0] ts = '0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b1;
   logic        ready_o;
   logic        valid_o;
   logic [2:0]  x_o;
   logic [2:0]  y_o;
   logic signed [7:0] count_o;
   logic        last_o;
`ifdef DVS_ACCUM_STATS_EN
   logic [15:0] frame_events_o;
`endif

   dvs_event_accumulator #(.WIDTH_P(8), .HEIGHT_P(8), .COUNT_W_P(8), .WINDOW_P(1000)) dut (
      .clk_i(clk), .reset_i(rst), .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
      .polarity_i(pol), .timestamp_i(ts), .ready_o(ready_o), .flush_i(flush_i),
      .valid_o(valid_o), .x_o(x_o), .y_o(y_o), .count_o(count_o), .last_o(last_o),
      .ready_i(ready_i)
`ifdef DVS_ACCUM_STATS_EN
      , .frame_events_o(frame_events_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic [7:0] c;
      logic       l;
   } pix_t;

   pix_t sb[$];
   int total = 0;
   int bad = 0;
   logic signed [7:0] mdl [8][8];
   bit rnd_rdy = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Queue one full row-major frame from the hand-filled model, then clear it.
   task automatic push_frame();
      pix_t e;
      for (int i = 0; i < 64; i++) begin
         e.x = 3'(i % 8);
         e.y = 3'(i / 8);
         e.c = mdl[i / 8][i % 8];
         e.l = (i == 63);
         sb.push_back(e);
      end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            mdl[r][c] = '0;
   endtask

   task automatic send_ev(input int x, input int y, input bit p, input int t);
      int n;
      n = 0;
      @(posedge clk); #1;
      valid_i = 1'b1; x_i = 3'(x); y_i = 3'(y); pol = p; ts = 16'(t);
      @(negedge clk);
      while (!ready_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) chk("event_accept_timeout", 0, 1);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   // Present an event, check ready_o on its first cycle, then let it through.
   task automatic present_check(input int x, input int y, input bit p, input int t,
                                input bit exp_rdy, input string name);
      int n;
      n = 0;
      @(posedge clk); #1;
      valid_i = 1'b1; x_i = 3'(x); y_i = 3'(y); pol = p; ts = 16'(t);
      @(negedge clk);
      chk(name, ready_o, exp_rdy);
      if (!exp_rdy) begin
         chk({name, "_no_valid_yet"}, valid_o, 0);
         @(negedge clk);
         chk({name, "_close_latency"}, valid_o, 1);
      end
      while (!ready_o && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) chk({name, "_timeout"}, 0, 1);
      else if (!exp_rdy) chk({name, "_frame_done_first"}, sb.size(), 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic flush_pulse();
      @(posedge clk); #1;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while ((sb.size() != 0 || valid_o) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         ready_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops expected pixels on handshakes, checks hold during stalls.
   initial begin
      pix_t cur, prev, e;
      bit stalled;
      stalled = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else if (valid_o) begin
            cur = '{x_o, y_o, count_o, last_o};
            if (stalled) chk("stall_hold", cur, prev);
            if (ready_i) begin
               if (sb.size() == 0) begin
                  chk("unexpected_pixel", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("pix_x", x_o, e.x);
                  chk("pix_y", y_o, e.y);
                  chk("pix_count", longint'($signed(count_o)), longint'($signed(e.c)));
                  chk("pix_last", last_o, e.l);
               end
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               prev = cur;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            mdl[r][c] = '0;
      #1;
      chk("rst_ready_o", ready_o, 1);
      chk("rst_valid_o", valid_o, 0);
      chk("rst_last_o", last_o, 0);
      chk("rst_x_o", x_o, 0);
      chk("rst_y_o", y_o, 0);
      chk("rst_count_o", count_o, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Net +2 at (2,1); ts=1010 closes the window and lands in the next frame.
      send_ev(2, 1, 1, 10);
      send_ev(2, 1, 1, 20);
      send_ev(2, 1, 1, 30);
      send_ev(2, 1, 0, 40);
      mdl[1][2] = 8'sd2;
      push_frame();
      present_check(5, 5, 1, 1010, 1'b0, "close_ts1010");
      mdl[5][5] = 8'sd1;
      push_frame();
      flush_pulse();
      wait_empty();

      // Saturation both ways.
      for (int i = 0; i < 200; i++) send_ev(0, 0, 1, 5000);
      mdl[0][0] = 8'sd127;
      push_frame();
      flush_pulse();
      wait_empty();
      for (int i = 0; i < 200; i++) send_ev(0, 0, 0, 6000);
      mdl[0][0] = -8'sd128;
      push_frame();
      flush_pulse();
      wait_empty();

      // Timestamp wrap.
      send_ev(3, 3, 1, 65000);
      present_check(3, 3, 1, 400, 1'b1, "wrap_delta_936");
      mdl[3][3] = 8'sd2;
      push_frame();
      present_check(4, 4, 1, 464, 1'b0, "wrap_delta_1000");
      mdl[4][4] = 8'sd1;
      push_frame();
      flush_pulse();
      wait_empty();

      // Flush with no open window is ignored, and with the opening event too.
      flush_pulse();
      repeat (2) begin
         @(negedge clk);
         chk("idle_flush_valid", valid_o, 0);
         chk("idle_flush_ready", ready_o, 1);
      end
      @(posedge clk); #1;
      valid_i = 1'b1; x_i = 3'd6; y_i = 3'd6; pol = 1'b1; ts = 16'd100; flush_i = 1'b1;
      @(negedge clk);
      chk("flush_first_accept", ready_o, 1);
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("flush_first_no_drain", valid_o, 0);
      end
      mdl[6][6] = 8'sd1;
      push_frame();
      flush_pulse();
      wait_empty();

      // Randomly stalled drain, then a second frame proves pixels were cleared.
      send_ev(1, 0, 1, 200);
      send_ev(7, 7, 1, 201);
      mdl[0][1] = 8'sd1;
      mdl[7][7] = 8'sd1;
      push_frame();
      rnd_rdy = 1'b1;
      flush_pulse();
      wait_empty();
      send_ev(1, 0, 0, 300);
      mdl[0][1] = -8'sd1;
      push_frame();
      flush_pulse();
      wait_empty();
      rnd_rdy = 1'b0;

      // Reset in the middle of a drain discards the rest of the frame.
      send_ev(2, 3, 1, 500);
      mdl[3][2] = 8'sd1;
      push_frame();
      flush_pulse();
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_drain_rst_valid", valid_o, 0);
      chk("mid_drain_rst_ready", ready_o, 1);
      chk("mid_drain_rst_last", last_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      send_ev(6, 2, 1, 700);
      mdl[2][6] = 8'sd1;
      push_frame();
      flush_pulse();
      wait_empty();

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
